// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package ifu_fetch_pkg;

    typedef enum logic [2:0] {
        S_BOOT,
        S_REQ,
        S_RESP,
        S_SEND,
        S_WAIT_WB
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        fetch_err;
    } if_id_t;

    localparam logic [31:0] NOP_INST      = 32'h0000_0013;
    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;

    function automatic logic pc_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Non-pipelined instruction fetch: one AXI4-Lite read per instruction,
// payload handed to decode over valid/ready, next PC supplied by write-back.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            ar_valid,
    input  logic            ar_ready,
    output logic [XLEN-1:0] ar_addr,
    input  logic            r_valid,
    output logic            r_ready,
    input  logic [XLEN-1:0] r_data,
    input  logic [1:0]      r_resp,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_inst,
    output logic            out_pvalid,
    output logic            out_fetch_err,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_next_pc
);

    ifu_state_e state, state_next;
    if_id_t     payload, payload_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= S_BOOT;
            payload.pc        <= RESET_PC;
            payload.inst      <= '0;
            payload.valid     <= 1'b0;
            payload.fetch_err <= 1'b0;
        end else begin
            state   <= state_next;
            payload <= payload_next;
        end
    end

    // Misalignment is resolved on the way into S_REQ so ar_valid never
    // rises for a bad PC; the fault payload goes straight to S_SEND.
    always_comb begin
        state_next   = state;
        payload_next = payload;
        case (state)
            S_BOOT: begin
                if (pc_misaligned(payload.pc)) begin
                    payload_next.inst      = NOP_INST;
                    payload_next.valid     = 1'b1;
                    payload_next.fetch_err = 1'b1;
                    state_next             = S_SEND;
                end else begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (ar_ready) state_next = S_RESP;
            end
            S_RESP: begin
                if (r_valid) begin
                    payload_next.inst      = (r_resp != AXI_RESP_OKAY) ? NOP_INST : r_data;
                    payload_next.valid     = 1'b1;
                    payload_next.fetch_err = (r_resp != AXI_RESP_OKAY);
                    state_next             = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) state_next = S_WAIT_WB;
            end
            S_WAIT_WB: begin
                if (wb_valid) begin
                    payload_next.pc = wb_next_pc;
                    if (pc_misaligned(wb_next_pc)) begin
                        payload_next.inst      = NOP_INST;
                        payload_next.valid     = 1'b1;
                        payload_next.fetch_err = 1'b1;
                        state_next             = S_SEND;
                    end else begin
                        state_next = S_REQ;
                    end
                end
            end
            default: state_next = S_BOOT;
        endcase
    end

    always_comb begin
        ar_valid      = (state == S_REQ);
        r_ready       = (state == S_RESP);
        out_valid     = (state == S_SEND);
        ar_addr       = payload.pc;
        out_pc        = payload.pc;
        out_inst      = payload.inst;
        out_pvalid    = payload.valid;
        out_fetch_err = payload.fetch_err;
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with an expected-payload scoreboard queue.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic        r_valid, r_ready;
    logic [31:0] r_data;
    logic [1:0]  r_resp;
    logic        out_valid, out_ready;
    logic [31:0] out_pc, out_inst;
    logic        out_pvalid, out_fetch_err;
    logic        wb_valid;
    logic [31:0] wb_next_pc;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ar_hs = 0;
    int r_hs  = 0;
    int ar_cycles = 0;
    int t_ar, t_out;
    if_id_t sbq[$];

    ifu_fetch #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr),
        .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_pvalid(out_pvalid), .out_fetch_err(out_fetch_err),
        .wb_valid(wb_valid), .wb_next_pc(wb_next_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ar_valid && ar_ready) ar_hs <= ar_hs + 1;
        if (r_valid && r_ready) r_hs <= r_hs + 1;
        if (ar_valid) ar_cycles <= ar_cycles + 1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                            input logic [1:0] resp, input int ar_dly, input int r_dly);
        if_id_t e;
        int n;
        e.pc        = pc;
        e.inst      = (resp != 2'b00) ? NOP_INST : data;
        e.valid     = 1'b1;
        e.fetch_err = (resp != 2'b00);
        sbq.push_back(e);
        n = 0;
        while (!ar_valid && n < 50) begin @(negedge clk); n++; end
        chk("ar_valid_seen", {31'b0, ar_valid}, 32'd1);
        t_ar = cyc;
        for (int i = 0; i < ar_dly; i++) begin
            chk("ar_addr_hold", ar_addr, pc);
            chk("ar_valid_hold", {31'b0, ar_valid}, 32'd1);
            @(negedge clk);
        end
        chk("ar_addr", ar_addr, pc);
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        n = 0;
        while (!r_ready && n < 50) begin @(negedge clk); n++; end
        chk("r_ready_seen", {31'b0, r_ready}, 32'd1);
        for (int i = 0; i < r_dly; i++) begin
            @(negedge clk);
            chk("r_ready_hold", {31'b0, r_ready}, 32'd1);
            chk("no_early_out", {31'b0, out_valid}, 32'd0);
        end
        r_valid = 1'b1;
        r_data  = data;
        r_resp  = resp;
        @(negedge clk);
        r_valid = 1'b0;
        r_data  = $urandom;
        r_resp  = 2'b00;
    endtask

    task automatic do_recv(input int stall);
        if_id_t e;
        int n;
        n = 0;
        while (!out_valid && n < 50) begin @(negedge clk); n++; end
        chk("out_valid_seen", {31'b0, out_valid}, 32'd1);
        t_out = cyc;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_underflow: got=payload exp=none");
        end else begin
            e = sbq.pop_front();
            for (int i = 0; i <= stall; i++) begin
                chk("out_valid_hold", {31'b0, out_valid}, 32'd1);
                chk("out_pc", out_pc, e.pc);
                chk("out_inst", out_inst, e.inst);
                chk("out_pvalid", {31'b0, out_pvalid}, {31'b0, e.valid});
                chk("out_fetch_err", {31'b0, out_fetch_err}, {31'b0, e.fetch_err});
                if (i < stall) @(negedge clk);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", {31'b0, out_valid}, 32'd0);
    endtask

    task automatic retire(input logic [31:0] npc);
        wb_valid   = 1'b1;
        wb_next_pc = npc;
        @(negedge clk);
        wb_valid   = 1'b0;
        wb_next_pc = $urandom;
    endtask

    initial begin
        int hs_a, hs_r, arc;
        rst = 1'b1; ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = 2'b00;
        out_ready = 1'b0; wb_valid = 1'b0; wb_next_pc = '0;
        repeat (2) @(negedge clk);
        chk("rst_ar_valid", {31'b0, ar_valid}, 32'd0);
        chk("rst_r_ready", {31'b0, r_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_inst", out_inst, 32'd0);
        chk("rst_out_pvalid", {31'b0, out_pvalid}, 32'd0);
        chk("rst_out_err", {31'b0, out_fetch_err}, 32'd0);
        rst = 1'b0;

        // Boot fetch: ar_valid one cycle after reset, zero-wait bus
        @(negedge clk);
        chk("boot_ar_valid_c1", {31'b0, ar_valid}, 32'd1);
        chk("boot_ar_addr_c1", ar_addr, RST_PC);
        do_fetch(RST_PC, 32'h0050_0093, 2'b00, 0, 0);
        do_recv(0);
        chk("latency", t_out - t_ar, 32'd2);

        // Stall in S_SEND; a stray wb_valid there must be ignored
        retire(32'h8000_0004);
        do_fetch(32'h8000_0004, 32'h0010_0113, 2'b00, 0, 0);
        wb_valid = 1'b1; wb_next_pc = 32'h1234_5670;
        @(negedge clk);
        wb_valid = 1'b0;
        do_recv(5);

        // Redirect with slow AR and R channels
        retire(32'h8000_0010);
        hs_a = ar_hs; hs_r = r_hs;
        do_fetch(32'h8000_0010, 32'h0020_0193, 2'b00, 3, 4);
        do_recv(1);
        chk("ar_hs_once", ar_hs - hs_a, 32'd1);
        chk("r_hs_once", r_hs - hs_r, 32'd1);

        // Bus error response
        retire(32'h8000_0014);
        do_fetch(32'h8000_0014, 32'hDEAD_BEEF, 2'b10, 0, 0);
        do_recv(0);

        // Misaligned redirect: no bus access at all
        arc = ar_cycles;
        retire(32'h8000_0006);
        sbq.push_back('{pc: 32'h8000_0006, inst: NOP_INST, valid: 1'b1, fetch_err: 1'b1});
        do_recv(0);
        chk("misaligned_no_ar", ar_cycles - arc, 32'd0);

        // Reset while waiting for read data; late r_valid must be dropped
        retire(32'h8000_0020);
        begin
            int n;
            n = 0;
            while (!ar_valid && n < 50) begin @(negedge clk); n++; end
            chk("mid_ar_valid", {31'b0, ar_valid}, 32'd1);
            chk("mid_ar_addr", ar_addr, 32'h8000_0020);
        end
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        chk("mid_in_resp", {31'b0, r_ready}, 32'd1);
        hs_r = r_hs;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_r_ready", {31'b0, r_ready}, 32'd0);
        r_valid = 1'b1; r_data = 32'h0000_0073; r_resp = 2'b00;
        @(negedge clk);
        r_valid = 1'b0;
        chk("mid_r_dropped", r_hs - hs_r, 32'd0);
        chk("mid_no_out", {31'b0, out_valid}, 32'd0);
        do_fetch(RST_PC, 32'h0030_0213, 2'b00, 0, 0);
        do_recv(0);
        chk("sb_drained", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch stage; sits directly upstream of the decode stage.
- Issues one AXI4-Lite read per instruction and presents {pc, inst, valid, fetch_err} to decode over a valid/ready handshake.
- Multi-cycle, non-pipelined: fetches the next instruction only after write-back reports the next PC. That PC is either pc+4 or a redirect target.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- XLEN, 32, address/data width; only 32 is supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ar_valid  out  1  read address valid
- ar_ready  in  1  read address accepted
- ar_addr  out  32  fetch address (= pc)
- r_valid  in  1  read data valid
- r_ready  out  1  read data accept
- r_data  in  32  instruction word
- r_resp  in  2  AXI response; non-zero means bus error
- out_valid  out  1  payload valid to decode
- out_ready  in  1  decode accepts payload
- out_pc  out  32  PC of fetched instruction
- out_inst  out  32  instruction word (32'h0000_0013 on error)
- out_pvalid  out  1  payload.valid bit; 1 for a real instruction
- out_fetch_err  out  1  bus error or misaligned PC on this fetch
- wb_valid  in  1  pulse: previous instruction retired, next PC available
- wb_next_pc  in  32  next PC (pc+4 or redirect target)

Behaviour:
- Reset (clk edge with rst=1):
  - state=S_BOOT, pc=RESET_PC.
  - ar_valid=0, r_ready=0, out_valid=0, out_inst=0, out_pvalid=0, out_fetch_err=0.
- Moore FSM; all handshake outputs are decoded from the registered state only.
  - S_BOOT: all valids 0; next cycle -> S_REQ.
  - S_REQ: ar_valid=1, ar_addr=pc.
    - ar_valid&&ar_ready -> S_RESP.
    - ar_addr held stable while ar_valid=1 and ar_ready=0.
  - S_RESP: r_ready=1.
    - On r_valid, latch inst_reg=r_data and err_reg=(r_resp!=0); -> S_SEND.
  - S_SEND: out_valid=1; payload comes from registers only.
    - out_valid&&out_ready -> S_WAIT_WB.
    - Payload stays stable while stalled.
  - S_WAIT_WB: all valids 0.
    - wb_valid -> pc<=wb_next_pc, -> S_REQ.
- Misaligned PC: if pc[1:0]!=0 when entering S_REQ, skip the bus access.
  - Go directly to S_SEND with err_reg=1 and inst_reg=32'h0000_0013.
  - ar_valid never asserts for that PC.
- Bus error: out_fetch_err=1, out_inst=32'h0000_0013 (NOP), out_pvalid=1. The downstream trap logic consumes the flag.
- Latency, zero-wait bus: S_REQ→S_RESP→S_SEND gives out_valid 2 cycles after the first ar_valid cycle.
- wb_valid in any state other than S_WAIT_WB is ignored. Write-back guarantees one pulse per retired instruction.
- Reset mid-transaction (S_RESP):
  - FSM returns to S_BOOT; the late r_valid is dropped because r_ready=0.
  - The slave is reset by the same rst.
- pc arithmetic is not done here; wb_next_pc is taken verbatim. PC wrap at 0xFFFF_FFFC is the upstream's concern.

Decomposition:
- Shared package: ifu_state_e {S_BOOT,S_REQ,S_RESP,S_SEND,S_WAIT_WB}, the if_id_t payload struct {pc,inst,valid,fetch_err}, NOP_INST constant, AXI_RESP_OKAY constant.
- No sub-module; single FSM plus pc/inst/err registers.

Test Plan:
- Reset then zero-wait bus with mem[0x8000_0000]=0x00500093 -> ar_addr=0x8000_0000 at cycle 1; out_valid at cycle 3 with out_inst=0x00500093, out_pc=0x8000_0000, out_fetch_err=0.
- out_ready held 0 for 5 cycles in S_SEND -> out_valid stays 1 and payload is constant; on out_ready=1 -> S_WAIT_WB, out_valid=0 next cycle.
- wb_valid with wb_next_pc=0x8000_0010 (redirect) -> next ar_addr=0x8000_0010.
- ar_ready delayed 3 cycles and r_valid delayed 4 cycles -> ar_addr stable throughout; exactly one AR handshake and one R handshake.
- r_resp=2'b10 -> out_fetch_err=1, out_inst=0x0000_0013, out_pvalid=1.
- wb_next_pc=0x8000_0006 -> no ar_valid; out_valid with out_fetch_err=1, out_pc=0x8000_0006.
- rst asserted in S_RESP with r_valid arriving the next cycle -> no out_valid; refetch from RESET_PC.
